// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, ALU
// operations, branch/move conditions, status codes and the condition evaluator.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

    function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                       input logic sf, input logic of);
        logic r;
        case (ifun)
            C_ALWAYS: r = 1'b1;
            C_LE:     r = (sf ^ of) | zf;
            C_L:      r = sf ^ of;
            C_E:      r = zf;
            C_NE:     r = !zf;
            C_GE:     r = !(sf ^ of);
            C_G:      r = !(sf ^ of) & !zf;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu64.sv
// Combinational Y86 ALU computing b op a, with zero/sign/overflow flags.
module alu64
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] y,
    output logic         zf,
    output logic         sf,
    output logic         of
);

    always_comb begin
        y  = '0;
        of = 1'b0;
        case (op)
            ALU_ADD: begin
                y  = b + a;
                of = (a[W-1] == b[W-1]) & (y[W-1] != b[W-1]);
            end
            ALU_SUB: begin
                y  = b - a;
                of = (b[W-1] != a[W-1]) & (y[W-1] != b[W-1]);
            end
            ALU_AND: y = b & a;
            ALU_XOR: y = b ^ a;
            default: y = '0;
        endcase
        zf = (y == '0);
        sf = y[W-1];
    end

endmodule

// File: rtl/exec_stage.sv
// Y86-64 execute stage: operand muxing into the ALU, condition-code register,
// Cnd evaluation and a single registered output slot with valid/ready.
module exec_stage
    import y86_pkg::*;
#(
    parameter int W          = 64,
    parameter int STACK_STEP = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_stat,
    input  logic [3:0]   in_icode,
    input  logic [3:0]   in_ifun,
    input  logic [W-1:0] in_valA,
    input  logic [W-1:0] in_valB,
    input  logic [W-1:0] in_valC,
    input  logic [3:0]   in_dstE,
    input  logic [3:0]   in_dstM,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_stat,
    output logic [3:0]   out_icode,
    output logic         out_cnd,
    output logic [W-1:0] out_valE,
    output logic [W-1:0] out_valA,
    output logic [3:0]   out_dstE,
    output logic [3:0]   out_dstM,
    output logic         cc_zf,
    output logic         cc_sf,
    output logic         cc_of
);

    localparam logic [W-1:0] STEP_W = W'(STACK_STEP);

    logic         valid_q, valid_d;
    logic [1:0]   stat_q, stat_d;
    logic [3:0]   icode_q, icode_d;
    logic         cnd_q, cnd_d;
    logic [W-1:0] vale_q, vale_d;
    logic [W-1:0] vala_q, vala_d;
    logic [3:0]   dste_q, dste_d;
    logic [3:0]   dstm_q, dstm_d;
    logic         zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic         halted_q, halted_d;

    logic [W-1:0] alu_a, alu_b, alu_y;
    alu_op_e      alu_op;
    logic         alu_zf, alu_sf, alu_of;
    logic         accept, cnd;

    // Every valE is formed as aluB op aluA so the stack adjust shares the ALU.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_ADD;
        case (in_icode)
            I_OPQ: begin
                alu_a  = in_valA;
                alu_b  = in_valB;
                alu_op = alu_op_e'(in_ifun[1:0]);
            end
            I_RRMOVQ: alu_a = in_valA;
            I_IRMOVQ: alu_a = in_valC;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = in_valC;
                alu_b = in_valB;
            end
            I_CALL, I_PUSHQ: begin
                alu_a  = STEP_W;
                alu_b  = in_valB;
                alu_op = ALU_SUB;
            end
            I_RET, I_POPQ: begin
                alu_a = STEP_W;
                alu_b = in_valB;
            end
            default: ;
        endcase
    end

    alu64 #(.W(W)) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y),
        .zf (alu_zf),
        .sf (alu_sf),
        .of (alu_of)
    );

    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready & !flush;
    // Cnd always looks at the registered CC, never at this instruction's flags.
    assign cnd      = cond_eval(in_ifun, zf_q, sf_q, of_q);

    always_comb begin
        valid_d  = valid_q;
        stat_d   = stat_q;
        icode_d  = icode_q;
        cnd_d    = cnd_q;
        vale_d   = vale_q;
        vala_d   = vala_q;
        dste_d   = dste_q;
        dstm_d   = dstm_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
        halted_d = halted_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            stat_d  = in_stat;
            icode_d = in_icode;
            cnd_d   = ((in_icode == I_RRMOVQ) || (in_icode == I_JXX)) ? cnd : 1'b0;
            vale_d  = alu_y;
            vala_d  = in_valA;
            dste_d  = ((in_icode == I_RRMOVQ) && !cnd) ? REG_NONE : in_dstE;
            dstm_d  = in_dstM;
            if ((in_icode == I_OPQ) && (in_stat == STAT_AOK) && !halted_q) begin
                zf_d = alu_zf;
                sf_d = alu_sf;
                of_d = alu_of;
            end
            if (in_stat != STAT_AOK) begin
                halted_d = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            stat_q   <= STAT_AOK;
            icode_q  <= 4'h0;
            cnd_q    <= 1'b0;
            vale_q   <= '0;
            vala_q   <= '0;
            dste_q   <= REG_NONE;
            dstm_q   <= REG_NONE;
            zf_q     <= 1'b1;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            stat_q   <= stat_d;
            icode_q  <= icode_d;
            cnd_q    <= cnd_d;
            vale_q   <= vale_d;
            vala_q   <= vala_d;
            dste_q   <= dste_d;
            dstm_q   <= dstm_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
            halted_q <= halted_d;
        end
    end

    assign out_valid = valid_q;
    assign out_stat  = stat_q;
    assign out_icode = icode_q;
    assign out_cnd   = cnd_q;
    assign out_valE  = vale_q;
    assign out_valA  = vala_q;
    assign out_dstE  = dste_q;
    assign out_dstM  = dstm_q;
    assign cc_zf     = zf_q;
    assign cc_sf     = sf_q;
    assign cc_of     = of_q;

endmodule

// File: tb/tb_exec_stage.sv
// Randomized and directed bench for exec_stage against a cycle-level
// behavioural model of the execute stage (signed arithmetic, flag table).
module tb_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_stat = 2'd0;
    logic [3:0]  in_icode = 4'h0;
    logic [3:0]  in_ifun = 4'h0;
    logic [63:0] in_valA = '0;
    logic [63:0] in_valB = '0;
    logic [63:0] in_valC = '0;
    logic [3:0]  in_dstE = 4'hF;
    logic [3:0]  in_dstM = 4'hF;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_stat;
    logic [3:0]  out_icode;
    logic        out_cnd;
    logic [63:0] out_valE;
    logic [63:0] out_valA;
    logic [3:0]  out_dstE;
    logic [3:0]  out_dstM;
    logic        cc_zf, cc_sf, cc_of;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: contents of the output slot after the most recent edge.
    logic        m_valid, m_cnd, m_zf, m_sf, m_of, m_halted;
    logic [1:0]  m_stat;
    logic [3:0]  m_icode, m_dstE, m_dstM;
    logic [63:0] m_valE, m_valA;

    exec_stage #(.W(64), .STACK_STEP(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
        .in_valA(in_valA), .in_valB(in_valB), .in_valC(in_valC),
        .in_dstE(in_dstE), .in_dstM(in_dstM),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_stat(out_stat), .out_icode(out_icode), .out_cnd(out_cnd),
        .out_valE(out_valE), .out_valA(out_valA),
        .out_dstE(out_dstE), .out_dstM(out_dstM),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 6))
            0: return 64'h0;
            1: return 64'h1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
        logic lt;
        lt = sf ^ of;
        case (fn)
            4'd0: return 1'b1;
            4'd1: return lt | zf;
            4'd2: return lt;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !lt;
            4'd6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (ic)
            4'h6: case (fn)
                4'd0: return b + a;
                4'd1: return b - a;
                4'd2: return b & a;
                default: return b ^ a;
            endcase
            4'h2: return a;
            4'h3: return c;
            4'h4, 4'h5: return b + c;
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            default: return 64'h0;
        endcase
    endfunction

    // Overflow as "true signed result does not fit in 64 bits".
    function automatic logic ref_of(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] s;
        if (fn == 4'd0) s = $signed({b[63], b}) + $signed({a[63], a});
        else if (fn == 4'd1) s = $signed({b[63], b}) - $signed({a[63], a});
        else return 1'b0;
        return (s > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -65'sh0_8000_0000_0000_0000);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_stat = 0; m_icode = 0; m_cnd = 0; m_valE = 0; m_valA = 0;
        m_dstE = 4'hF; m_dstM = 4'hF; m_zf = 1; m_sf = 0; m_of = 0; m_halted = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".zf"}, 64'(cc_zf), 64'(m_zf));
        check({tag, ".sf"}, 64'(cc_sf), 64'(m_sf));
        check({tag, ".of"}, 64'(cc_of), 64'(m_of));
        if (m_valid) begin
            check({tag, ".stat"}, 64'(out_stat), 64'(m_stat));
            check({tag, ".icode"}, 64'(out_icode), 64'(m_icode));
            check({tag, ".cnd"}, 64'(out_cnd), 64'(m_cnd));
            check({tag, ".valE"}, out_valE, m_valE);
            check({tag, ".valA"}, out_valA, m_valA);
            check({tag, ".dstE"}, 64'(out_dstE), 64'(m_dstE));
            check({tag, ".dstM"}, 64'(out_dstM), 64'(m_dstM));
        end
    endtask

    // Called at a negedge: apply inputs, update model for the coming edge, compare after it.
    task automatic drive(input string tag, input logic v, input logic [1:0] st,
                         input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic ordy, input logic fl);
        logic acc, cd, t_zf;
        logic [63:0] t;
        in_valid = v; in_stat = st; in_icode = ic; in_ifun = fn;
        in_valA = a; in_valB = b; in_valC = c; in_dstE = de; in_dstM = dm;
        out_ready = ordy; flush = fl;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || ordy));
        acc = v && (!m_valid || ordy) && !fl;
        if (acc) begin
            cd = ref_cond(fn, m_zf, m_sf, m_of);
            t  = ref_vale(ic, fn, a, b, c);
            m_valid = 1;
            m_stat  = st;
            m_icode = ic;
            m_cnd   = (ic == 4'h2 || ic == 4'h7) ? cd : 1'b0;
            m_valE  = t;
            m_valA  = a;
            m_dstE  = (ic == 4'h2 && !cd) ? 4'hF : de;
            m_dstM  = dm;
            if (ic == 4'h6 && st == 2'd0 && !m_halted) begin
                t_zf = (t == 64'h0);
                m_zf = t_zf;
                m_sf = t[63];
                m_of = ref_of(fn, a, b);
            end
            if (st != 2'd0) m_halted = 1;
            $display("accept %s: stat=%0d icode=%h ifun=%h valE=%h cnd=%0d dstE=%h",
                     tag, st, ic, fn, t, m_cnd, m_dstE);
        end else if (fl || ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        logic [63:0] held;
        logic [3:0]  ic, fn;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.dstE", 64'(out_dstE), 64'hF);
        check("reset.dstM", 64'(out_dstM), 64'hF);
        check("reset.stat", 64'(out_stat), 64'd0);
        check("reset.valE", out_valE, 64'd0);
        check("reset.zf", 64'(cc_zf), 64'd1);
        check("reset.sf", 64'(cc_sf), 64'd0);
        check("reset.of", 64'(cc_of), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Subtraction with no flags.
        drive("sub_plain", 1, 0, 4'h6, 4'h1, 64'h1, 64'h4000_0000_0000_0004, 0, 4'h2, 4'hF, 1, 0);
        check("sub_plain.valE_const", out_valE, 64'h4000_0000_0000_0003);
        check("sub_plain.flags_const", {cc_zf, cc_sf, cc_of}, 64'd0);

        // Subtraction overflow followed by branches.
        drive("sub_ovf", 1, 0, 4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 0, 4'h2, 4'hF, 1, 0);
        check("sub_ovf.valE_const", out_valE, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_ovf.of_const", 64'(cc_of), 64'd1);
        drive("jl", 1, 0, 4'h7, 4'h2, 0, 0, 64'h100, 4'hF, 4'hF, 1, 0);
        check("jl.cnd_const", 64'(out_cnd), 64'd1);
        drive("je", 1, 0, 4'h7, 4'h3, 0, 0, 64'h100, 4'hF, 4'hF, 1, 0);
        check("je.cnd_const", 64'(out_cnd), 64'd0);

        // Untaken and taken cmov.
        drive("xor_zero", 1, 0, 4'h6, 4'h3, 64'd5, 64'd5, 0, 4'h4, 4'hF, 1, 0);
        check("xor_zero.zf_const", 64'(cc_zf), 64'd1);
        drive("cmovne", 1, 0, 4'h2, 4'h4, 64'd9, 0, 0, 4'h3, 4'hF, 1, 0);
        check("cmovne.dstE_const", 64'(out_dstE), 64'hF);
        drive("cmove", 1, 0, 4'h2, 4'h3, 64'd9, 0, 0, 4'h3, 4'hF, 1, 0);
        check("cmove.dstE_const", 64'(out_dstE), 64'h3);

        // Backpressure: stalled xor must not touch CC or the held slot.
        drive("add_pre", 1, 0, 4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h1, 4'hF, 1, 0);
        held = out_valE;
        for (int i = 0; i < 3; i++) begin
            drive("stall", 1, 0, 4'h6, 4'h3, 64'd7, 64'd7, 0, 4'h5, 4'hF, 0, 0);
            check("stall.valE_held", out_valE, held);
            check("stall.zf_held", 64'(cc_zf), 64'd0);
        end
        drive("release", 1, 0, 4'h6, 4'h3, 64'd7, 64'd7, 0, 4'h5, 4'hF, 1, 0);
        for (int i = 0; i < 4; i++)
            drive("stream", 1, 0, 4'h3, 4'h0, 0, 0, 64'(i + 100), 4'(i), 4'hF, 1, 0);

        // Flush drops a concurrent OPq that would have produced zero.
        drive("add_pre2", 1, 0, 4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h1, 4'hF, 1, 0);
        drive("flush", 1, 0, 4'h6, 4'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'h1, 4'hF, 1, 1);
        check("flush.zf_const", 64'(cc_zf), 64'd0);

        // Randomized traffic with AOK status only.
        for (int i = 0; i < 250; i++) begin
            ic = 4'($urandom_range(0, 11));
            fn = (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 7));
            drive("rand", 1'($urandom_range(0, 3) != 0), 0, ic, fn, rnd64(), rnd64(), rnd64(),
                  4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 15) == 0));
        end

        // Sticky halt freezes CC.
        drive("add_pre3", 1, 0, 4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h1, 4'hF, 1, 0);
        drive("ins", 1, 2'd3, 4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 1, 0);
        check("ins.stat_const", 64'(out_stat), 64'd3);
        drive("halted_xor", 1, 0, 4'h6, 4'h3, 64'd9, 64'd9, 0, 4'h1, 4'hF, 1, 0);
        check("halted_xor.zf_const", 64'(cc_zf), 64'd0);

        // Asynchronous reset mid-stream, slot occupied and stalled.
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset.out_valid", 64'(out_valid), 64'd0);
        check("areset.zf", 64'(cc_zf), 64'd1);
        check("areset.sf", 64'(cc_sf), 64'd0);
        check("areset.of", 64'(cc_of), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_reset_add", 1, 0, 4'h6, 4'h0, 64'd1, 64'd1, 0, 4'h1, 4'hF, 1, 0);
        check("post_reset_add.zf_const", 64'(cc_zf), 64'd0);
        drive("drain", 0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
